// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback and drives the ALU, muxes and write enables.
// Optional ILLEGAL_TRAP_EN: illegal opcodes trap into HALT and raise a sticky illegal_op output.
module multicycle_control #(
  parameter int OPW  = 6,
  parameter int ALUW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  opcode,
  input  logic            Beq_alu,
  input  logic            mem_ready,
  output logic [ALUW-1:0] ALU_selection,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      pc_source,
  output logic            pc_write,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            iord,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic [3:0]      state
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic            illegal_op
`endif
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    ALU_WB   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WB   = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    HALT     = 4'd11
  } state_t;

  localparam logic [OPW-1:0]  OP_LW   = OPW'(6'b100001);
  localparam logic [OPW-1:0]  OP_SW   = OPW'(6'b100010);
  localparam logic [OPW-1:0]  OP_BEQ  = OPW'(6'b110000);
  localparam logic [OPW-1:0]  OP_BNE  = OPW'(6'b110001);
  localparam logic [OPW-1:0]  OP_J    = OPW'(6'b110010);
  localparam logic [ALUW-1:0] ALU_ADD = ALUW'(4'b0010);
  localparam logic [ALUW-1:0] ALU_SUB = ALUW'(4'b0011);

  state_t cur;
  logic   r_class;   // 1 = current ALU instruction is R-type (writes rd)

  function automatic logic alu_op_legal(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h9, 4'hc: alu_op_legal = 1'b1;
      default:                                             alu_op_legal = 1'b0;
    endcase
  endfunction

  logic op_ok, is_r, is_i, is_lw, is_sw, is_beq, is_bne, is_j;

  always_comb begin
    op_ok  = alu_op_legal(opcode[3:0]);
    is_r   = (opcode[OPW-1:OPW-2] == 2'b00) && op_ok;
    is_i   = (opcode[OPW-1:OPW-2] == 2'b01) && op_ok;
    is_lw  = (opcode == OP_LW);
    is_sw  = (opcode == OP_SW);
    is_beq = (opcode == OP_BEQ);
    is_bne = (opcode == OP_BNE);
    is_j   = (opcode == OP_J);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= FETCH;
      r_class <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_op <= 1'b0;
`endif
    end else begin
      case (cur)
        FETCH:    if (mem_ready) cur <= DECODE;
        DECODE: begin
          if (is_r) begin
            cur     <= EXEC_R;
            r_class <= 1'b1;
          end else if (is_i) begin
            cur     <= EXEC_I;
            r_class <= 1'b0;
          end else if (is_lw || is_sw) begin
            cur <= MEM_ADDR;
          end else if (is_beq || is_bne) begin
            cur <= BRANCH;
          end else if (is_j) begin
            cur <= JUMP;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            cur        <= HALT;
            illegal_op <= 1'b1;
`else
            cur <= FETCH;
`endif
          end
        end
        EXEC_R,
        EXEC_I:   cur <= ALU_WB;
        ALU_WB:   cur <= FETCH;
        MEM_ADDR: cur <= is_sw ? MEM_WR : MEM_RD;
        MEM_RD:   if (mem_ready) cur <= MEM_WB;
        MEM_WB:   cur <= FETCH;
        MEM_WR:   if (mem_ready) cur <= FETCH;
        BRANCH,
        JUMP:     cur <= FETCH;
`ifdef ILLEGAL_TRAP_EN
        HALT:     cur <= HALT;
`endif
        default:  cur <= FETCH;
      endcase
    end
  end

  always_comb begin
    ALU_selection = ALU_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    pc_source     = 2'd0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    case (cur)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'd1;
        pc_write  = mem_ready;
      end
      DECODE:   alu_src_b = 2'd3;
      EXEC_R: begin
        alu_src_a     = 1'b1;
        ALU_selection = ALUW'(opcode[3:0]);
      end
      EXEC_I: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'd2;
        ALU_selection = ALUW'(opcode[3:0]);
      end
      ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = r_class;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        ALU_selection = ALU_SUB;
        pc_source     = 2'd1;
        pc_write      = is_bne ? ~Beq_alu : Beq_alu;
      end
      JUMP: begin
        pc_source = 2'd2;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    // Reset abandons any in-flight access: no enable may fire on the reset edge.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state/controls queued by instruction, compared each cycle.
module tb_multicycle_control;
  logic       clk = 1'b0, reset = 1'b1;
  logic [5:0] opcode = '0;
  logic       Beq_alu = 1'b0, mem_ready = 1'b0;
  logic [3:0] ALU_selection, state;
  logic       alu_src_a, pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg;
  logic [1:0] alu_src_b, pc_source;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  multicycle_control #(.OPW(6), .ALUW(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .Beq_alu(Beq_alu), .mem_ready(mem_ready),
    .ALU_selection(ALU_selection), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .state(state)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] alu;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg;
  } ctrl_t;

  typedef struct {
    logic [3:0] st;
    ctrl_t      val;
    ctrl_t      msk;
    logic       rdy, rst, beq, ill;
    logic [5:0] op;
  } sb_t;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
                         S_ALU_WB = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WB = 4'd7,
                         S_MEM_WR = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_HALT = 4'd11;

  sb_t sbq[$];
  int  n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 R-ALU, 1 I-ALU, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 J, 7 illegal
  function automatic int kind(input logic [5:0] op);
    logic legal;
    legal = op[3:0] inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h9, 4'hc};
    if (op[5:4] == 2'b00 && legal) return 0;
    if (op[5:4] == 2'b01 && legal) return 1;
    case (op)
      6'b100001: return 2;
      6'b100010: return 3;
      6'b110000: return 4;
      6'b110001: return 5;
      6'b110010: return 6;
      default:   return 7;
    endcase
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic rst,
                      input logic [5:0] op, input logic beq, input logic ill);
    sb_t   e;
    ctrl_t v, m;
    v = '0;
    m = '0;
    {m.pc_write, m.ir_write, m.mem_read, m.mem_write, m.reg_write} = 5'h1f;
    case (st)
      S_FETCH: begin
        v.mem_read = 1; v.ir_write = 1; v.pc_write = rdy; v.alu = 4'b0010; v.src_b = 2'd1;
        m.alu = 4'hf; m.src_a = 1; m.src_b = 2'h3; m.pc_src = 2'h3; m.iord = 1;
      end
      S_DECODE:   begin v.src_b = 2'd3; v.alu = 4'b0010; m.alu = 4'hf; m.src_a = 1; m.src_b = 2'h3; end
      S_EXEC_R:   begin v.src_a = 1; v.alu = op[3:0]; m.alu = 4'hf; m.src_a = 1; m.src_b = 2'h3; end
      S_EXEC_I:   begin v.src_a = 1; v.src_b = 2'd2; v.alu = op[3:0]; m.alu = 4'hf; m.src_a = 1; m.src_b = 2'h3; end
      S_ALU_WB:   begin v.reg_write = 1; v.reg_dst = (op[5:4] == 2'b00); m.reg_dst = 1; m.mem_to_reg = 1; end
      S_MEM_ADDR: begin v.src_a = 1; v.src_b = 2'd2; v.alu = 4'b0010; m.alu = 4'hf; m.src_a = 1; m.src_b = 2'h3; end
      S_MEM_RD:   begin v.mem_read = 1; v.iord = 1; m.iord = 1; end
      S_MEM_WB:   begin v.reg_write = 1; v.mem_to_reg = 1; m.reg_dst = 1; m.mem_to_reg = 1; end
      S_MEM_WR:   begin v.mem_write = 1; v.iord = 1; m.iord = 1; end
      S_BRANCH: begin
        v.src_a = 1; v.alu = 4'b0011; v.pc_src = 2'd1; v.pc_write = (op == 6'b110001) ? ~beq : beq;
        m.alu = 4'hf; m.src_a = 1; m.src_b = 2'h3; m.pc_src = 2'h3;
      end
      S_JUMP:     begin v.pc_src = 2'd2; v.pc_write = 1; m.pc_src = 2'h3; end
      default: ;
    endcase
    if (rst) begin
      {v.pc_write, v.ir_write, v.mem_read, v.mem_write, v.reg_write} = 5'h0;
      m = '0;
      {m.pc_write, m.ir_write, m.mem_read, m.mem_write, m.reg_write} = 5'h1f;
    end
    e.st = st; e.val = v; e.msk = m; e.rdy = rdy; e.rst = rst; e.op = op; e.beq = beq; e.ill = ill;
    sbq.push_back(e);
  endtask

  // Expected cycle-by-cycle trace for one instruction; fw/mw are fetch/memory wait cycles.
  task automatic push_instr(input logic [5:0] op, input logic beq, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push(S_FETCH, 1'b0, 1'b0, op, beq, 1'b0);
    push(S_FETCH, 1'b1, 1'b0, op, beq, 1'b0);
    push(S_DECODE, 1'($urandom_range(0, 1)), 1'b0, op, beq, 1'b0);
    case (kind(op))
      0: begin push(S_EXEC_R, 1'($urandom_range(0, 1)), 0, op, beq, 0); push(S_ALU_WB, 1'($urandom_range(0, 1)), 0, op, beq, 0); end
      1: begin push(S_EXEC_I, 1'($urandom_range(0, 1)), 0, op, beq, 0); push(S_ALU_WB, 1'($urandom_range(0, 1)), 0, op, beq, 0); end
      2: begin
        push(S_MEM_ADDR, 1'($urandom_range(0, 1)), 0, op, beq, 0);
        for (int i = 0; i < mw; i++) push(S_MEM_RD, 0, 0, op, beq, 0);
        push(S_MEM_RD, 1, 0, op, beq, 0);
        push(S_MEM_WB, 1'($urandom_range(0, 1)), 0, op, beq, 0);
      end
      3: begin
        push(S_MEM_ADDR, 1'($urandom_range(0, 1)), 0, op, beq, 0);
        for (int i = 0; i < mw; i++) push(S_MEM_WR, 0, 0, op, beq, 0);
        push(S_MEM_WR, 1, 0, op, beq, 0);
      end
      4, 5: push(S_BRANCH, 1'($urandom_range(0, 1)), 0, op, beq, 0);
      6:    push(S_JUMP, 1'($urandom_range(0, 1)), 0, op, beq, 0);
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) push(S_HALT, 1'($urandom_range(0, 1)), 0, op, beq, 1);
`endif
      end
    endcase
  endtask

  initial begin
    sb_t   e;
    ctrl_t act;
    int    cyc = 0;
    push(S_FETCH, 1'b1, 1'b1, 6'b000010, 1'b0, 1'b0);
    push_instr(6'b000010, 0, 0, 0);
    push_instr(6'b000010, 0, 1, 0);
    push_instr(6'b100001, 0, 0, 2);
    push_instr(6'b100010, 0, 0, 1);
    push_instr(6'b110000, 1, 0, 0);
    push_instr(6'b110000, 0, 0, 0);
    push_instr(6'b110001, 1, 0, 0);
    push_instr(6'b110001, 0, 0, 0);
    push_instr(6'b010111, 0, 0, 0);
    push_instr(6'b110010, 0, 0, 0);
    push_instr(6'b011100, 0, 0, 0);
    // SW aborted by reset during its memory wait
    push(S_FETCH, 1, 0, 6'b100010, 0, 0);
    push(S_DECODE, 0, 0, 6'b100010, 0, 0);
    push(S_MEM_ADDR, 0, 0, 6'b100010, 0, 0);
    push(S_MEM_WR, 0, 0, 6'b100010, 0, 0);
    push(S_MEM_WR, 1, 1, 6'b100010, 0, 0);
    push_instr(6'b000011, 0, 0, 0);
    push_instr(6'b000110, 0, 0, 0);
`ifdef ILLEGAL_TRAP_EN
    push(S_HALT, 1, 1, 6'b000110, 0, 1);
`endif
    push_instr(6'b000100, 0, 0, 0);
    push_instr(6'b100001, 0, 0, 0);

    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge clk);
      reset = e.rst; mem_ready = e.rdy; opcode = e.op; Beq_alu = e.beq;
      #1;
      act = {ALU_selection, alu_src_a, alu_src_b, pc_source, pc_write, ir_write,
             mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg};
      chk($sformatf("c%0d state", cyc), 32'(state), 32'(e.st));
      chk($sformatf("c%0d st%0d ctrl", cyc, e.st), 32'(act & e.msk), 32'(e.val & e.msk));
      chk($sformatf("c%0d pcw_regw_excl", cyc), 32'(pc_write & reg_write), 32'(0));
`ifdef ILLEGAL_TRAP_EN
      chk($sformatf("c%0d illegal_op", cyc), 32'(illegal_op), 32'(e.ill));
`endif
      cyc++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle CPU control FSM: the driving end of the ALU interface.
- Decodes the latched instruction opcode and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Drives ALU_selection, mux selects and write enables for PC, IR, register file and memory.
- Consumes Beq_alu back from the ALU to resolve branches; handshakes with memory via mem_ready.

Parameters:
OPW, 6, opcode width (instruction bits [31:26])
ALUW, 4, ALU_selection width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
opcode  input  OPW  IR[31:26], valid from DECODE onward
Beq_alu  input  1  ALU equality flag (A==B)
mem_ready  input  1  memory access complete this cycle
ALU_selection  output  ALUW  ALU operation code
alu_src_a  output  1  0=PC, 1=reg A
alu_src_b  output  2  0=reg B, 1=const 4, 2=sext imm, 3=sext imm<<2
pc_source  output  2  0=ALU result, 1=ALUOut reg, 2=jump target
pc_write  output  1  load PC
ir_write  output  1  load IR
mem_read  output  1  memory read request
mem_write  output  1  memory write request
iord  output  1  0=PC address, 1=ALUOut address
reg_write  output  1  register file write
reg_dst  output  1  0=rt, 1=rd
mem_to_reg  output  1  0=ALUOut, 1=MDR
state  output  4  current state, for debug

Behaviour:
- Opcode classes:
  - 00xxxx: R-ALU, op=opcode[3:0].
  - 01xxxx: I-ALU, op=opcode[3:0], B=sext imm.
  - 100001: LW. 100010: SW.
  - 110000: BEQ. 110001: BNE. 110010: J.
  - Legal ALU ops: 0000 mov, 0001 not, 0010 add, 0011 sub, 0100 or, 0101 and, 0111 slt, 1001 li, 1100 swi. Any other op, or any other opcode, is illegal.
- States and encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ALU_WB=4, MEM_ADDR=5, MEM_RD=6, MEM_WB=7, MEM_WR=8, BRANCH=9, JUMP=10, HALT=11.
- Moore outputs decoded from state. All enables are 0 in states not listed below. ALU_selection defaults to 0010.
- FETCH:
  - mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=1, ALU_selection=0010, pc_source=0.
  - pc_write=mem_ready.
  - Hold in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=3, ALU_selection=0010 (branch target into ALUOut). Next state by class; illegal opcode -> see Optional Feature.
- EXEC_R: alu_src_a=1, alu_src_b=0, ALU_selection=opcode[3:0]. Next ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=2, ALU_selection=opcode[3:0]. Next ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=1 when coming from EXEC_R, 0 when coming from EXEC_I (reg_dst from a 1-bit registered class flag). Next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ALU_selection=0010. Next MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready=1, then FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, ALU_selection=0011, pc_source=1.
  - pc_write=Beq_alu for BEQ, ~Beq_alu for BNE.
  - Next FETCH.
- JUMP: pc_source=2, pc_write=1. Next FETCH.
- Cycle counts with zero memory wait: R/I=4, LW=5, SW=4, BEQ/BNE=3, J=3. Each wait cycle of mem_ready=0 adds one cycle.
- Reset:
  - While reset=1, all enables are forced to 0 combinationally.
  - At the clock edge with reset=1: state<=FETCH, class flag<=0.
  - Reset mid-access (MEM_RD/MEM_WR/FETCH) abandons the access; no write enable is asserted on that edge.
- mem_ready is ignored in states that do not access memory.
- pc_write and reg_write are never asserted in the same cycle.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - Illegal opcode in DECODE -> HALT.
  - HALT asserts all enables 0 and stays in HALT until reset.
  - Adds output illegal_op (1 bit, reset 0), set on entry to HALT and sticky until reset.
- Undefined:
  - Illegal opcode in DECODE -> FETCH (executes as a 2-cycle NOP).
  - No illegal_op port; HALT is unreachable.

Test Plan:
- ADD: opcode=000010, mem_ready=1 -> states 0,1,2,4,0. ALU_selection=0010 in EXEC_R; reg_write=1, reg_dst=1 in ALU_WB only.
- LW with 2 wait cycles: opcode=100001, mem_ready low 2 cycles in MEM_RD -> 7 cycles total. mem_read=1 held through waits; MEM_WB asserts reg_write=1, mem_to_reg=1.
- BEQ: Beq_alu=1 -> pc_write=1, pc_source=1 in BRANCH. Repeat with Beq_alu=0 -> pc_write=0. BNE gives the inverse result.
- I-type slt: opcode=010111 -> ALU_selection=0111, alu_src_b=2 in EXEC_I; reg_dst=0 in ALU_WB.
- Illegal opcode 000110:
  - With ILLEGAL_TRAP_EN: -> HALT, illegal_op=1, stays in HALT until reset.
  - Without: -> FETCH after DECODE, no reg_write.
- Reset asserted during MEM_WR wait -> next state FETCH, mem_write=0 while reset=1; a following R-type executes normally.
